// File: rtl/bus_ws_ctrl.sv
// 8085 bus-cycle controller: address demux, chip-select decode, per-region wait states, DMA hold arbitration.
// Optional build macro WS_PROG_EN: ROM wait count comes from an IO-writable register at port WS_PORT.
module bus_ws_ctrl #(
    parameter logic [15:0] ROM_TOP = 16'h7FFF,
    parameter int          WS_W    = 3,
    parameter logic [WS_W-1:0] ROM_WS = 3'd2,
    parameter logic [WS_W-1:0] RAM_WS = 3'd0,
    parameter logic [WS_W-1:0] IO_WS  = 3'd1,
    parameter logic [7:0]  WS_PORT = 8'hF0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  AD,
    input  logic [7:0]  A_HI,
    input  logic        ALE,
    input  logic        RDn,
    input  logic        WRn,
    input  logic        IO_Mn,
    input  logic        DMA_REQ,
    input  logic [15:0] DMA_ADDR,
    input  logic        HLDA,
    output logic [15:0] ADD,
    output logic        ROM_CSn,
    output logic        RAM_CSn,
    output logic        IO_CSn,
    output logic        READY,
    output logic        HOLD,
    output logic        DMA_GNT
);

    // State registers are named signals so checkers can bind to wait_state / dma_state.
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DONE} wait_state_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_GRANT, D_REL} dma_state_t;

    wait_state_t     wait_state;
    dma_state_t      dma_state;
    logic [15:0]     addr_latch;
    logic [WS_W-1:0] cnt;
    logic [WS_W-1:0] rom_ws_eff;
    logic [WS_W-1:0] region_ws;
    logic            strobe;
    logic            in_rom;

    assign strobe  = ~RDn | ~WRn;
    assign ADD     = DMA_GNT ? DMA_ADDR : addr_latch;
    assign in_rom  = (ADD <= ROM_TOP);
    assign ROM_CSn = ~(~IO_Mn & in_rom & ~RDn);
    assign RAM_CSn = ~(~IO_Mn & ~in_rom & strobe);
    assign IO_CSn  = ~(IO_Mn & strobe);

    // A write into the ROM window selects nothing, so it completes with no wait.
    always_comb begin
        region_ws = '0;
        if (IO_Mn)
            region_ws = IO_WS;
        else if (in_rom)
            region_ws = (~RDn) ? rom_ws_eff : '0;
        else
            region_ws = RAM_WS;
    end

`ifdef WS_PROG_EN
    logic [WS_W-1:0] ws_reg;

    always_ff @(posedge CLK) begin
        if (RESET)
            ws_reg <= ROM_WS;
        else if (IO_Mn && !WRn && ADD[7:0] == WS_PORT && wait_state == W_IDLE)
            ws_reg <= AD[WS_W-1:0];
    end

    assign rom_ws_eff = ws_reg;
`else
    assign rom_ws_eff = ROM_WS;
`endif

    always_ff @(posedge CLK) begin
        if (RESET)
            addr_latch <= '0;
        else if (ALE && !DMA_GNT)
            addr_latch <= {A_HI, AD};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_state <= W_IDLE;
            cnt        <= '0;
            READY      <= 1'b1;
        end else begin
            case (wait_state)
                W_IDLE: begin
                    if (strobe) begin
                        if (region_ws != '0) begin
                            wait_state <= W_WAIT;
                            cnt        <= region_ws - WS_W'(1);
                            READY      <= 1'b0;
                        end else begin
                            wait_state <= W_DONE;
                        end
                    end
                end
                W_WAIT: begin
                    if (!strobe) begin
                        wait_state <= W_IDLE;
                        READY      <= 1'b1;
                    end else if (cnt == '0) begin
                        wait_state <= W_DONE;
                        READY      <= 1'b1;
                    end else begin
                        cnt <= cnt - WS_W'(1);
                    end
                end
                W_DONE: begin
                    if (!strobe)
                        wait_state <= W_IDLE;
                end
                default: begin
                    wait_state <= W_IDLE;
                    READY      <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dma_state <= D_IDLE;
            HOLD      <= 1'b0;
            DMA_GNT   <= 1'b0;
        end else begin
            case (dma_state)
                D_IDLE: begin
                    if (DMA_REQ) begin
                        dma_state <= D_REQ;
                        HOLD      <= 1'b1;
                    end
                end
                D_REQ: begin
                    if (HLDA) begin
                        dma_state <= D_GRANT;
                        DMA_GNT   <= 1'b1;
                    end else if (!DMA_REQ) begin
                        dma_state <= D_IDLE;
                        HOLD      <= 1'b0;
                    end
                end
                D_GRANT: begin
                    if (!DMA_REQ) begin
                        dma_state <= D_REL;
                        DMA_GNT   <= 1'b0;
                        HOLD      <= 1'b0;
                    end
                end
                D_REL: begin
                    // Wait for the CPU to take the bus back before accepting a new request.
                    if (!HLDA)
                        dma_state <= D_IDLE;
                end
                default: begin
                    dma_state <= D_IDLE;
                    HOLD      <= 1'b0;
                    DMA_GNT   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ws_ctrl.sv
// Bench for bus_ws_ctrl: directed bus/DMA/reset scenarios plus random bus cycles against a transaction-level model.
// Honours WS_PROG_EN the same way as the design.
module tb_bus_ws_ctrl;

    localparam logic [15:0] ROM_TOP = 16'h7FFF;
    localparam int          ROM_WS  = 2;
    localparam int          RAM_WS  = 0;
    localparam int          IO_WS   = 1;
    localparam logic [7:0]  WS_PORT = 8'hF0;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  AD;
    logic [7:0]  A_HI;
    logic        ALE;
    logic        RDn;
    logic        WRn;
    logic        IO_Mn;
    logic        DMA_REQ;
    logic [15:0] DMA_ADDR;
    logic        HLDA;
    logic [15:0] ADD;
    logic        ROM_CSn;
    logic        RAM_CSn;
    logic        IO_CSn;
    logic        READY;
    logic        HOLD;
    logic        DMA_GNT;

    int n_checks = 0;
    int n_pass   = 0;
    int rom_ws_m = ROM_WS;
    logic [15:0] last_addr = 16'h0000;
    logic [0:0]  exp_q[$];

    bus_ws_ctrl dut (
        .CLK(CLK), .RESET(RESET), .AD(AD), .A_HI(A_HI), .ALE(ALE),
        .RDn(RDn), .WRn(WRn), .IO_Mn(IO_Mn), .DMA_REQ(DMA_REQ),
        .DMA_ADDR(DMA_ADDR), .HLDA(HLDA), .ADD(ADD), .ROM_CSn(ROM_CSn),
        .RAM_CSn(RAM_CSn), .IO_CSn(IO_CSn), .READY(READY), .HOLD(HOLD),
        .DMA_GNT(DMA_GNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Edge then a small settle; registered outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int model_ws(input bit io, input bit wr, input logic [15:0] a);
        if (io) return IO_WS;
        if (a <= ROM_TOP) return wr ? 0 : rom_ws_m;
        return RAM_WS;
    endfunction

    task automatic check_cs(input bit io, input bit wr, input logic [15:0] a);
        check("rom_csn", ROM_CSn, !(!io && a <= ROM_TOP && !wr));
        check("ram_csn", RAM_CSn, !(!io && a > ROM_TOP));
        check("io_csn",  IO_CSn,  !io);
    endtask

    task automatic pop_ready(input string tag);
        logic [0:0] e;
        e = exp_q.pop_front();
        check(tag, READY, e);
    endtask

    // One CPU bus cycle: address phase, strobe held (or aborted after abort_at cycles), release.
    task automatic bus_cycle(input bit io, input bit wr, input logic [15:0] a,
                             input logic [7:0] data, input int extra, input int abort_at);
        int  w;
        int  held;
        bit  abort;
        IO_Mn = io; ALE = 1'b1; A_HI = a[15:8]; AD = a[7:0];
        tick();
        ALE = 1'b0; AD = data;
        last_addr = a;
        check("add_latch", ADD, a);
        w = model_ws(io, wr, a);
        if (wr) WRn = 1'b0; else RDn = 1'b0;
        #1;
        check_cs(io, wr, a);
        abort = (abort_at > 0) && (abort_at < w);
        held  = abort ? abort_at : w + extra;
        for (int k = 1; k <= held; k++) exp_q.push_back((k > w) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
        for (int k = 0; k < held; k++) begin
            tick();
            pop_ready("ready_hold");
        end
        RDn = 1'b1; WRn = 1'b1;
        tick();
        pop_ready("ready_release");
`ifdef WS_PROG_EN
        if (io && wr && a[7:0] == WS_PORT) rom_ws_m = int'(data[2:0]);
`endif
    endtask

    initial begin
        int exp_prog;
        RESET = 1'b1; AD = '0; A_HI = '0; ALE = 1'b0; RDn = 1'b1; WRn = 1'b1;
        IO_Mn = 1'b0; DMA_REQ = 1'b1; DMA_ADDR = 16'h0000; HLDA = 1'b0;

        // Reset held two cycles with a pending DMA request
        tick(); tick();
        check("rst_ready", READY, 1'b1);
        check("rst_hold", HOLD, 1'b0);
        check("rst_gnt", DMA_GNT, 1'b0);
        check("rst_add", ADD, 16'h0000);
        check("rst_csn", {ROM_CSn, RAM_CSn, IO_CSn}, 3'b111);
        RESET = 1'b0; DMA_REQ = 1'b0;
        tick();

        // Directed bus cycles
        bus_cycle(1'b0, 1'b0, 16'h0123, 8'h00, 2, 0);  // ROM read, 2 waits
        bus_cycle(1'b0, 1'b1, 16'h8000, 8'h11, 1, 0);  // RAM write, no wait
        bus_cycle(1'b0, 1'b1, 16'h0010, 8'h22, 1, 0);  // write into ROM window
        bus_cycle(1'b1, 1'b0, 16'h0040, 8'h00, 1, 0);  // IO read, 1 wait
        bus_cycle(1'b0, 1'b0, 16'h0200, 8'h00, 0, 1);  // ROM read aborted in WAIT

        // DMA handshake
        DMA_REQ = 1'b1; DMA_ADDR = 16'hA5A5;
        tick();
        check("dma_hold_req", HOLD, 1'b1);
        check("dma_gnt_req", DMA_GNT, 1'b0);
        tick();
        check("dma_hold_wait", HOLD, 1'b1);
        HLDA = 1'b1;
        tick();
        check("dma_gnt", DMA_GNT, 1'b1);
        check("dma_add", ADD, 16'hA5A5);
        ALE = 1'b1; A_HI = 8'h12; AD = 8'h34;
        tick();
        ALE = 1'b0;
        check("dma_ale_ignored", ADD, 16'hA5A5);
        IO_Mn = 1'b0; WRn = 1'b0;
        #1;
        check_cs(1'b0, 1'b1, 16'hA5A5);
        tick();
        check("dma_ready", READY, 1'b1);
        WRn = 1'b1;
        tick();
        DMA_REQ = 1'b0;
        tick();
        check("dma_rel_hold", HOLD, 1'b0);
        check("dma_rel_gnt", DMA_GNT, 1'b0);
        check("dma_add_back", ADD, last_addr);
        DMA_REQ = 1'b1;
        tick();
        check("dma_rel_ignore", HOLD, 1'b0);
        tick();
        check("dma_rel_ignore2", HOLD, 1'b0);
        HLDA = 1'b0;
        tick();
        check("dma_back_idle", HOLD, 1'b0);
        tick();
        check("dma_rereq", HOLD, 1'b1);
        DMA_REQ = 1'b0;
        tick();
        check("dma_withdraw", HOLD, 1'b0);

        // Random bus cycles
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            bit io, wr;
            int ab;
            a  = 16'($urandom_range(0, 65535));
            io = ($urandom_range(0, 3) == 0);
            wr = $urandom_range(0, 1) == 1;
            if (io && $urandom_range(0, 2) == 0) a[7:0] = WS_PORT;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            bus_cycle(io, wr, a, 8'($urandom_range(0, 255)), $urandom_range(0, 2), ab);
        end

        // Programmable ROM wait count
        bus_cycle(1'b1, 1'b1, {8'h00, WS_PORT}, 8'h05, 0, 0);
`ifdef WS_PROG_EN
        exp_prog = 5;
`else
        exp_prog = ROM_WS;
`endif
        check("ws_model", rom_ws_m, exp_prog);
        bus_cycle(1'b0, 1'b0, 16'h0400, 8'h00, 1, 0);

        // Reset in the middle of a ROM wait with HOLD asserted
        DMA_REQ = 1'b1;
        tick();
        check("mid_hold", HOLD, 1'b1);
        IO_Mn = 1'b0; ALE = 1'b1; A_HI = 8'h00; AD = 8'h80;
        tick();
        ALE = 1'b0; RDn = 1'b0;
        tick();
        check("mid_ready_low", READY, 1'b0);
        RESET = 1'b1;
        tick();
        check("mid_rst_ready", READY, 1'b1);
        check("mid_rst_hold", HOLD, 1'b0);
        check("mid_rst_add", ADD, 16'h0000);
        RESET = 1'b0; RDn = 1'b1; DMA_REQ = 1'b0;
        rom_ws_m = ROM_WS;
        tick();
        bus_cycle(1'b0, 1'b0, 16'h0123, 8'h00, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_ws_ctrl.md
Name: bus_ws_ctrl

Overview:
- Bus-cycle controller between the 8085 multiplexed bus and the memory/IO devices (ROM, RAM, IO ports).
- Demultiplexes and latches the low address byte.
- Decodes ROM, RAM and IO chip selects.
- Generates READY with a per-region number of wait states.
- Arbitrates a single DMA requester onto the bus through the CPU HOLD/HLDA handshake.

Parameters:
- ROM_TOP, 16'h7FFF, last memory address decoded as ROM; addresses above it are RAM.
- WS_W, 3, width of the wait-state counter and of each wait-state value.
- ROM_WS, 3'd2, wait states inserted on a ROM access.
- RAM_WS, 3'd0, wait states inserted on a RAM access.
- IO_WS, 3'd1, wait states inserted on an IO access.
- WS_PORT, 8'hF0, IO port of the wait-state register (used only with WS_PROG_EN).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- AD  in  8  multiplexed address/data bus from the CPU.
- A_HI  in  8  CPU high address byte A[15:8].
- ALE  in  1  address latch enable.
- RDn  in  1  read strobe, active low.
- WRn  in  1  write strobe, active low.
- IO_Mn  in  1  1 = IO cycle, 0 = memory cycle.
- DMA_REQ  in  1  DMA bus request.
- DMA_ADDR  in  16  DMA address; used while DMA_GNT=1.
- HLDA  in  1  CPU hold acknowledge.
- ADD  out  16  demultiplexed address to the devices.
- ROM_CSn  out  1  ROM select, active low.
- RAM_CSn  out  1  RAM select, active low.
- IO_CSn  out  1  IO select, active low.
- READY  out  1  registered ready to the CPU.
- HOLD  out  1  hold request to the CPU.
- DMA_GNT  out  1  bus granted to DMA.

Behaviour:
- Reset values:
  - ADD = 0; ROM_CSn = RAM_CSn = IO_CSn = 1.
  - READY = 1; HOLD = 0; DMA_GNT = 0.
  - Both FSMs go to IDLE; counter = 0; wait-state register = ROM_WS.
- Address latch:
  - On a rising edge with ALE=1 and DMA_GNT=0: latch <= {A_HI, AD}.
  - ADD = latch when DMA_GNT=0; ADD = DMA_ADDR when DMA_GNT=1. ALE is ignored while DMA_GNT=1.
- Decode (combinational from ADD, IO_Mn, RDn, WRn):
  - strobe = ~RDn | ~WRn.
  - ROM_CSn = 0 iff IO_Mn=0 & ADD<=ROM_TOP & RDn=0. ROM is never selected on a write.
  - RAM_CSn = 0 iff IO_Mn=0 & ADD>ROM_TOP & strobe.
  - IO_CSn = 0 iff IO_Mn=1 & strobe.
- Wait FSM (states IDLE, WAIT, DONE):
  - Region wait count W is ROM_WS, RAM_WS or IO_WS, chosen from the decode.
  - A memory write below ROM_TOP uses W=0.
  - IDLE:
    - strobe & W>0: go to WAIT, cnt <= W-1, READY <= 0.
    - strobe & W=0: go to DONE; READY stays 1.
  - WAIT:
    - cnt==0: go to DONE, READY <= 1.
    - Otherwise cnt <= cnt-1.
    - Net effect: READY is low for exactly W cycles, starting the edge after strobe is first sampled low.
  - DONE: when RDn=WRn=1, return to IDLE. A new strobe is not recognised until the previous strobe is released.
  - A strobe released during WAIT is treated as an aborted cycle: go to IDLE, READY <= 1 on the same edge.
- DMA FSM (states IDLE, REQ, GRANT, REL):
  - IDLE: DMA_REQ=1 → REQ, HOLD <= 1.
  - REQ:
    - HLDA=1 → GRANT, DMA_GNT <= 1.
    - DMA_REQ dropped before HLDA → IDLE, HOLD <= 0.
  - GRANT: DMA_REQ=0 → REL, DMA_GNT <= 0, HOLD <= 0.
  - REL: HLDA=0 → IDLE. A new DMA_REQ is ignored until the FSM is back in IDLE.
  - The wait FSM serves DMA cycles identically; the strobes are driven by the DMA master.
- RESET asserted mid-cycle: all state and outputs return to reset values on that edge.
  - An in-progress wait is abandoned and READY returns to 1.
  - HOLD and DMA_GNT drop immediately.

Optional Feature:
- Macro: WS_PROG_EN.
- When defined, the ROM wait count comes from a WS_W-bit register instead of ROM_WS.
- Register write:
  - Condition: rising edge with IO_Mn=1, WRn=0, ADD[7:0]==WS_PORT and wait FSM in IDLE.
  - Action: reg <= AD[WS_W-1:0].
  - Takes effect from the next ROM access.
- The register resets to ROM_WS.
- When the macro is undefined, there is no register and port WS_PORT is an ordinary IO port.

Test Plan:
- Reset: assert RESET 2 cycles with DMA_REQ=1 → READY=1, HOLD=0, DMA_GNT=0, all CSn=1, ADD=0.
- ROM read: ALE with A_HI=8'h01, AD=8'h23, then RDn=0, IO_Mn=0 → ADD=16'h0123, ROM_CSn=0, READY low exactly 2 cycles, then 1 until RDn=1.
- RAM write: address 16'h8000, WRn=0 → RAM_CSn=0, ROM_CSn=1, READY never drops; write to 16'h0010 → ROM_CSn stays 1.
- IO read port 8'h40: IO_Mn=1, RDn=0 → IO_CSn=0, READY low 1 cycle; releasing RDn during WAIT (ROM_WS=2 case) → READY=1 on that edge.
- DMA: DMA_REQ=1 → HOLD=1 next edge; HLDA=1 → DMA_GNT=1 and ADD follows DMA_ADDR=16'hA5A5 (RAM_CSn=0 on WRn=0); DMA_REQ=0 → HOLD=DMA_GNT=0; new DMA_REQ ignored until HLDA=0.
- WS_PROG_EN: IO write of 8'h05 to port 8'hF0, then ROM read → READY low exactly 5 cycles; without macro → 2 cycles.
